// File: rtl/udp_deadlock_report_latch.sv
// Qualifies the deadlock monitor's block indication over a persistence window and
// emits one timestamped report per episode, with a sticky flag and saturating count.
module udp_deadlock_report_latch #(
    parameter int INFO_W         = 16,
    parameter int PERSIST_CYCLES = 64,
    parameter int TS_W           = 32,
    parameter int CNT_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block_in,
    input  logic [INFO_W-1:0] axis_block_info_in,
    input  logic              clear,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [INFO_W-1:0] report_info,
    output logic [TS_W-1:0]   report_timestamp,
    output logic              deadlock_flag,
    output logic [CNT_W-1:0]  event_count
);

    localparam logic [15:0] Q_LAST = 16'(PERSIST_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_REPORT, S_HOLD} state_t;

    state_t             r_state;
    logic [15:0]        r_q;
    logic [TS_W-1:0]    r_ts;
    logic [TS_W-1:0]    r_ts_cap;
    logic [INFO_W-1:0]  r_info;
    logic               r_valid;
    logic               r_flag;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_enter_report;

    assign w_accept = r_valid & report_ready;

    always_comb begin
        w_enter_report = 1'b0;
        case (r_state)
            S_IDLE:    w_enter_report = block_in && (PERSIST_CYCLES == 1);
            S_QUALIFY: w_enter_report = block_in && (r_q == Q_LAST);
            default:   w_enter_report = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_ts     <= '0;
            r_ts_cap <= '0;
            r_info   <= '0;
            r_valid  <= 1'b0;
            r_flag   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;

            // A new episode outranks a simultaneous clear so it is never lost.
            if (w_enter_report)
                r_flag <= 1'b1;
            else if (clear)
                r_flag <= 1'b0;

            if (clear)
                r_cnt <= '0;
            else if (w_accept && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (block_in) begin
                        r_ts_cap <= r_ts;
                        r_info   <= axis_block_info_in;
                        if (PERSIST_CYCLES == 1) begin
                            r_state <= S_REPORT;
                            r_valid <= 1'b1;
                        end else begin
                            r_q     <= 16'd1;
                            r_state <= S_QUALIFY;
                        end
                    end
                end
                S_QUALIFY: begin
                    if (!block_in) begin
                        r_state <= S_IDLE;
                        r_q     <= '0;
                        r_info  <= '0;
                    end else begin
                        r_info <= r_info | axis_block_info_in;
                        if (r_q == Q_LAST) begin
                            r_state <= S_REPORT;
                            r_valid <= 1'b1;
                            r_q     <= '0;
                        end else begin
                            r_q <= r_q + 16'd1;
                        end
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
                        r_valid <= 1'b0;
                        r_state <= block_in ? S_HOLD : S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Still the same episode until block_in drops at least once.
                    if (!block_in)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign report_valid     = r_valid;
    assign report_info      = r_info;
    assign report_timestamp = r_ts_cap;
    assign deadlock_flag    = r_flag;
    assign event_count      = r_cnt;

endmodule

// File: tb/tb_udp_deadlock_report_latch.sv
// Directed bench: one P=4 instance and one P=1/CNT_W=2 instance, scoreboarded reports.
module tb_udp_deadlock_report_latch;

    typedef struct {
        logic [31:0] ts;
        logic [15:0] info;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset;

    logic        a_block, a_clear, a_ready, a_valid, a_flag;
    logic [15:0] a_info_in, a_info;
    logic [31:0] a_ts;
    logic [7:0]  a_count;

    logic        b_block, b_clear, b_ready, b_valid, b_flag;
    logic [15:0] b_info_in, b_info;
    logic [31:0] b_ts;
    logic [1:0]  b_count;

    rec_t        qa[$];
    rec_t        qb[$];
    logic [31:0] m_ts;
    int          checks = 0;
    int          errors = 0;
    int          a_valid_cycles = 0;
    int          b_valid_cycles = 0;

    always #5 clock = ~clock;

    udp_deadlock_report_latch #(
        .INFO_W(16), .PERSIST_CYCLES(4), .TS_W(32), .CNT_W(8)
    ) dut_a (
        .clock(clock), .reset(reset), .block_in(a_block), .axis_block_info_in(a_info_in),
        .clear(a_clear), .report_valid(a_valid), .report_ready(a_ready), .report_info(a_info),
        .report_timestamp(a_ts), .deadlock_flag(a_flag), .event_count(a_count)
    );

    udp_deadlock_report_latch #(
        .INFO_W(16), .PERSIST_CYCLES(1), .TS_W(32), .CNT_W(2)
    ) dut_b (
        .clock(clock), .reset(reset), .block_in(b_block), .axis_block_info_in(b_info_in),
        .clear(b_clear), .report_valid(b_valid), .report_ready(b_ready), .report_info(b_info),
        .report_timestamp(b_ts), .deadlock_flag(b_flag), .event_count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare any presented report against the scoreboard front, pop on handshake, then clock.
    task automatic cyc();
        logic rst_now;
        if (a_valid === 1'b1) begin
            a_valid_cycles++;
            if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
            else begin
                chk("a_info", a_info, qa[0].info);
                chk("a_timestamp", a_ts, qa[0].ts);
                if (a_ready) void'(qa.pop_front());
            end
        end
        if (b_valid === 1'b1) begin
            b_valid_cycles++;
            if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
            else begin
                chk("b_info", b_info, qb[0].info);
                chk("b_timestamp", b_ts, qb[0].ts);
                if (b_ready) void'(qb.pop_front());
            end
        end
        rst_now = reset;
        @(posedge clock);
        #1;
        m_ts = rst_now ? 32'd0 : m_ts + 32'd1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_info"}, a_info, 0);
        chk({tag, "_ts"}, a_ts, 0);
        chk({tag, "_flag"}, a_flag, 0);
        chk({tag, "_count"}, a_count, 0);
    endtask

    initial begin
        reset = 1'b1; m_ts = '0;
        a_block = 0; a_info_in = 0; a_clear = 0; a_ready = 1;
        b_block = 0; b_info_in = 0; b_clear = 0; b_ready = 1;
        cycles(2);
        reset = 1'b0;
        chk_a_zero("reset");

        // Basic qualify: episode starts at ts=10, report presented at ts=14.
        while (m_ts < 32'd10) cyc();
        a_valid_cycles = 0;
        qa.push_back('{ts: 32'd10, info: 16'h00DE});
        a_block = 1; a_info_in = 16'h000E;
        cycles(2);
        a_info_in = 16'h00D0;
        cycles(2);
        chk("basic_valid_at_14", a_valid, 1);
        chk("basic_flag_at_14", a_flag, 1);
        cycles(2);
        a_block = 0; a_info_in = 0;
        cyc();
        $display("basic: valid_cycles=%0d count=%0d flag=%0b", a_valid_cycles, a_count, a_flag);
        chk("basic_valid_cycles", a_valid_cycles, 1);
        chk("basic_count", a_count, 1);
        chk("basic_flag", a_flag, 1);

        // Clear alone.
        a_clear = 1; cyc(); a_clear = 0;
        chk("clear_flag", a_flag, 0);
        chk("clear_count", a_count, 0);

        // Glitch reject.
        a_valid_cycles = 0;
        a_block = 1; a_info_in = 16'h0101; cycles(3);
        a_block = 0; a_info_in = 0; cyc();
        a_block = 1; a_info_in = 16'h0101; cycles(3);
        a_block = 0; a_info_in = 0; cycles(3);
        $display("glitch: valid_cycles=%0d flag=%0b count=%0d", a_valid_cycles, a_flag, a_count);
        chk("glitch_valid_cycles", a_valid_cycles, 0);
        chk("glitch_flag", a_flag, 0);
        chk("glitch_count", a_count, 0);

        // Backpressure: held 20 cycles unaccepted, then accepted on the 21st.
        a_ready = 0;
        qa.push_back('{ts: m_ts, info: 16'h0005});
        a_block = 1; a_info_in = 16'h0005;
        cycles(4);
        chk("bp_valid_start", a_valid, 1);
        cycles(20);
        a_ready = 1; cyc();
        cycles(10);
        chk("bp_valid_cycles", a_valid_cycles, 21);
        chk("bp_hold_no_valid", a_valid, 0);
        a_block = 0; a_info_in = 0; cyc();
        qa.push_back('{ts: m_ts, info: 16'h0005});
        a_block = 1; a_info_in = 16'h0005;
        cycles(3);
        chk("bp_not_early", a_valid, 0);
        cyc();
        chk("bp_second_valid", a_valid, 1);
        cyc();
        a_block = 0; a_info_in = 0; cyc();
        $display("backpressure: valid_cycles=%0d count=%0d", a_valid_cycles, a_count);
        chk("bp_total_valid", a_valid_cycles, 22);
        chk("bp_count", a_count, 2);

        // Clear races.
        a_clear = 1; cyc(); a_clear = 0;
        chk("race_pre_flag", a_flag, 0);
        a_ready = 0;
        qa.push_back('{ts: m_ts, info: 16'h0A00});
        a_block = 1; a_info_in = 16'h0A00;
        cycles(3);
        a_clear = 1; cyc(); a_clear = 0;
        chk("race_entry_valid", a_valid, 1);
        chk("race_entry_flag", a_flag, 1);
        cyc();
        a_ready = 1; a_clear = 1; cyc(); a_clear = 0;
        $display("clear_race: count=%0d flag=%0b valid=%0b", a_count, a_flag, a_valid);
        chk("race_hs_count", a_count, 0);
        chk("race_hs_valid", a_valid, 0);
        a_block = 0; a_info_in = 0; cyc();

        // Reset while qualifying.
        a_block = 1; a_info_in = 16'h0003; cycles(2);
        reset = 1; a_block = 0; a_info_in = 0; cyc(); reset = 0;
        chk_a_zero("rst_qualify");

        // Reset while a report is pending; the record is dropped.
        a_ready = 0;
        qa.push_back('{ts: m_ts, info: 16'h0007});
        a_block = 1; a_info_in = 16'h0007; cycles(4);
        chk("rst_report_pending", a_valid, 1);
        reset = 1; a_block = 0; a_info_in = 0; cyc(); reset = 0;
        qa.delete();
        chk_a_zero("rst_report");

        // Normal episode afterwards; timestamp reflects ts restarted from 0.
        a_ready = 1;
        cycles(2);
        qa.push_back('{ts: m_ts, info: 16'h0030});
        a_block = 1; a_info_in = 16'h0030; cycles(4);
        chk("post_rst_valid", a_valid, 1);
        cyc();
        a_block = 0; a_info_in = 0; cyc();
        $display("post_reset: ts_model=%0d count=%0d flag=%0b", m_ts, a_count, a_flag);
        chk("post_rst_count", a_count, 1);
        chk("post_rst_flag", a_flag, 1);

        // P=1 with a 2-bit saturating counter.
        b_valid_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            qb.push_back('{ts: m_ts, info: 16'(k + 1)});
            b_block = 1; b_info_in = 16'(k + 1); cyc();
            b_block = 0; b_info_in = 0;
            chk("sat_valid_next_cycle", b_valid, 1);
            cyc();
            $display("saturate: episode=%0d count=%0d", k, b_count);
            chk("sat_count", b_count, (k < 3) ? (k + 1) : 3);
            cyc();
        end
        chk("sat_valid_cycles", b_valid_cycles, 5);
        chk("sat_flag", b_flag, 1);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
